// File: rtl/alu_arb_pkg.sv
// Shared types for alu_arbiter: FSM states and ALU operation codes.
package alu_arb_pkg;

  localparam int ALU_W  = 32;
  localparam int ALU_CW = 3;
  localparam int ALU_FW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_arb_state_e;

  localparam logic [ALU_CW-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_CW-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_CW-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_CW-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_CW-1:0] ALU_XOR = 3'b100;
  localparam logic [ALU_CW-1:0] ALU_SLT = 3'b101;
  localparam logic [ALU_CW-1:0] ALU_SLL = 3'b110;
  localparam logic [ALU_CW-1:0] ALU_SRL = 3'b111;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU. Flag = {carry/borrow, negative, zero}; carry is
// the add carry-out, or the unsigned borrow for subtract, and 0 otherwise.
module ALU
  import alu_arb_pkg::*;
(
  input  logic [ALU_W-1:0]  scrA,
  input  logic [ALU_W-1:0]  scrB,
  input  logic [ALU_CW-1:0] AluControl,
  output logic [ALU_W-1:0]  ALUresult,
  output logic [ALU_FW-1:0] Flag
);

  logic [ALU_W:0]   sum;
  logic [ALU_W-1:0] res;
  logic             carry;

  always_comb begin
    sum   = '0;
    res   = '0;
    carry = 1'b0;
    case (AluControl)
      ALU_ADD: begin
        sum   = {1'b0, scrA} + {1'b0, scrB};
        res   = sum[ALU_W-1:0];
        carry = sum[ALU_W];
      end
      ALU_SUB: begin
        res   = scrA - scrB;
        carry = (scrA < scrB);
      end
      ALU_AND: res = scrA & scrB;
      ALU_OR:  res = scrA | scrB;
      ALU_XOR: res = scrA ^ scrB;
      ALU_SLT: res = {{(ALU_W-1){1'b0}}, ($signed(scrA) < $signed(scrB))};
      ALU_SLL: res = scrA << scrB[4:0];
      ALU_SRL: res = scrA >> scrB[4:0];
      default: res = '0;
    endcase
  end

  assign ALUresult = res;
  assign Flag      = {carry, res[ALU_W-1], (res == '0)};

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU: IDLE (grant) -> EXEC -> RESP.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (r0 wins); default is round-robin.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3,
  parameter int FLAG_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  input  logic              r1_valid,
  output logic              r0_ready,
  output logic              r1_ready,
  input  logic [WIDTH-1:0]  r0_scrA,
  input  logic [WIDTH-1:0]  r0_scrB,
  input  logic [WIDTH-1:0]  r1_scrA,
  input  logic [WIDTH-1:0]  r1_scrB,
  input  logic [CTRL_W-1:0] r0_ctrl,
  input  logic [CTRL_W-1:0] r1_ctrl,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_id,
  output logic [WIDTH-1:0]  res_data,
  output logic [FLAG_W-1:0] res_flag,
  output alu_arb_state_e    dbg_state_o
);

  // Handshake: a requester's operation transfers in the cycle where its
  // valid and ready are both high; the result transfers when res_valid and
  // res_ready are both high. Ready is only ever offered in IDLE.

  alu_arb_state_e    state_q, state_d;
  logic [WIDTH-1:0]  op_a_q, op_b_q;
  logic [CTRL_W-1:0] op_ctrl_q;
  logic              op_id_q;
  logic [WIDTH-1:0]  res_data_q;
  logic [FLAG_W-1:0] res_flag_q;
  logic              res_id_q;
  logic [WIDTH-1:0]  alu_result;
  logic [FLAG_W-1:0] alu_flag;
  logic              grant_id;
  logic              accept;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant_id = ~r0_valid;
`else
  logic last_q;

  // On a tie the requester that did not win last time goes first.
  assign grant_id = (r0_valid && r1_valid) ? ~last_q : r1_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_q <= 1'b1;
    else if (accept) last_q <= grant_id;
  end
`endif

  assign accept   = (state_q == IDLE) && (r0_valid || r1_valid);
  assign r0_ready = accept && !grant_id;
  assign r1_ready = accept &&  grant_id;

  always_comb begin
    state_d   = state_q;
    res_valid = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: state_d = RESP;
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_ctrl_q <= '0;
      op_id_q   <= 1'b0;
    end else if (accept) begin
      op_a_q    <= grant_id ? r1_scrA : r0_scrA;
      op_b_q    <= grant_id ? r1_scrB : r0_scrB;
      op_ctrl_q <= grant_id ? r1_ctrl : r0_ctrl;
      op_id_q   <= grant_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data_q <= '0;
      res_flag_q <= '0;
      res_id_q   <= 1'b0;
    end else if (state_q == EXEC) begin
      res_data_q <= alu_result;
      res_flag_q <= alu_flag;
      res_id_q   <= op_id_q;
    end
  end

  ALU u_alu (
    .scrA       (op_a_q),
    .scrB       (op_b_q),
    .AluControl (op_ctrl_q),
    .ALUresult  (alu_result),
    .Flag       (alu_flag)
  );

  assign res_data    = res_data_q;
  assign res_flag    = res_flag_q;
  assign res_id      = res_id_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; expectations follow ALU_ARB_FIXED_PRIO_EN.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0_valid = 1'b0, r1_valid = 1'b0;
  logic        r0_ready, r1_ready;
  logic [31:0] r0_scrA = '0, r0_scrB = '0, r1_scrA = '0, r1_scrB = '0;
  logic [2:0]  r0_ctrl = '0, r1_ctrl = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic        res_id;
  logic [31:0] res_data;
  logic [2:0]  res_flag;
  alu_arb_state_e dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic exp_id;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .CTRL_W(3), .FLAG_W(3)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r1_valid(r1_valid),
    .r0_ready(r0_ready), .r1_ready(r1_ready),
    .r0_scrA(r0_scrA), .r0_scrB(r0_scrB), .r1_scrA(r1_scrA), .r1_scrB(r1_scrB),
    .r0_ctrl(r0_ctrl), .r1_ctrl(r1_ctrl),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_data(res_data), .res_flag(res_flag), .dbg_state_o(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk); #1;
    chk("rst_state", dbg_state, IDLE);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_ready", {r0_ready, r1_ready}, 0);
    chk("rst_data", res_data, 0);
    chk("rst_flag", res_flag, 0);
    chk("rst_id", res_id, 0);
    rst = 1'b0;

    // Single request: 0x00200476 + 0xFFFFFFFC = 0x1_00200472 (carry out)
    @(negedge clk);
    r0_valid = 1'b1; r0_scrA = 32'h0020_0476; r0_scrB = 32'hFFFF_FFFC; r0_ctrl = ALU_ADD;
    #1;
    chk("single_r0_ready", r0_ready, 1);
    chk("single_r1_ready", r1_ready, 0);
    @(negedge clk); r0_valid = 1'b0; #1;
    chk("single_exec_ready", {r0_ready, r1_ready}, 0);
    chk("single_exec_valid", res_valid, 0);
    @(negedge clk); #1;
    chk("single_valid", res_valid, 1);
    chk("single_data", res_data, 32'h0020_0472);
    chk("single_flag", res_flag, 3'b100);
    chk("single_id", res_id, 0);
    @(negedge clk); #1;
    chk("single_done", res_valid, 0);

    // Contention from fresh reset: r0 ADD 1+2=3, r1 AND -> 0xF000F000 (negative)
    rst_pulse();
    @(negedge clk);
    r0_valid = 1'b1; r0_scrA = 32'd1; r0_scrB = 32'd2; r0_ctrl = ALU_ADD;
    r1_valid = 1'b1; r1_scrA = 32'hF0F0_F0F0; r1_scrB = 32'hFF00_FF00; r1_ctrl = ALU_AND;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = i[0];
`endif
      #1;
      chk("cont_r0_ready", r0_ready, !exp_id);
      chk("cont_r1_ready", r1_ready, exp_id);
      @(negedge clk); #1;
      chk("cont_exec_ready", {r0_ready, r1_ready}, 0);
      @(negedge clk); #1;
      chk("cont_valid", res_valid, 1);
      chk("cont_id", res_id, exp_id);
      chk("cont_data", res_data, exp_id ? 32'hF000_F000 : 32'd3);
      chk("cont_flag", res_flag, exp_id ? 3'b010 : 3'b000);
      chk("cont_resp_ready", {r0_ready, r1_ready}, 0);
      @(negedge clk);
    end
    // r0 drops: the lone r1 request wins
    r0_valid = 1'b0;
    #1;
    chk("drop_r1_ready", r1_ready, 1);
    chk("drop_r0_ready", r0_ready, 0);
    @(negedge clk); r1_valid = 1'b0; #1;
    @(negedge clk); #1;
    chk("drop_id", res_id, 1);
    chk("drop_data", res_data, 32'hF000_F000);

    // Backpressure: r1 SUB 5-7 = 0xFFFFFFFE (negative, borrow)
    rst_pulse();
    @(negedge clk);
    r1_valid = 1'b1; r1_scrA = 32'd5; r1_scrB = 32'd7; r1_ctrl = ALU_SUB;
    #1;
    chk("bp_r1_ready", r1_ready, 1);
    @(negedge clk); r1_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk); r0_valid = 1'b1; r0_scrA = 32'd1; r0_scrB = 32'd2; r0_ctrl = ALU_ADD;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_valid", res_valid, 1);
      chk("bp_data", res_data, 32'hFFFF_FFFE);
      chk("bp_flag", res_flag, 3'b110);
      chk("bp_id", res_id, 1);
      chk("bp_ready", {r0_ready, r1_ready}, 0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    #1;
    chk("bp_hs_valid", res_valid, 1);
    chk("bp_hs_ready", r0_ready, 0);
    @(negedge clk); #1;
    chk("bp_resume_ready", r0_ready, 1);
    chk("bp_resume_valid", res_valid, 0);
    @(negedge clk); r0_valid = 1'b0; #1;
    @(negedge clk); #1;
    chk("bp_next_data", res_data, 32'd3);
    chk("bp_next_id", res_id, 0);

    // Reset mid-EXEC discards the operation
    @(negedge clk);
    r0_valid = 1'b1; r0_scrA = 32'd10; r0_scrB = 32'd20; r0_ctrl = ALU_ADD;
    #1;
    chk("mid_r0_ready", r0_ready, 1);
    @(negedge clk); r0_valid = 1'b0; #1;
    chk("mid_state_exec", dbg_state, EXEC);
    rst = 1'b1; #1;
    chk("mid_rst_state", dbg_state, IDLE);
    chk("mid_rst_data", res_data, 0);
    chk("mid_rst_valid", res_valid, 0);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("mid_no_valid", res_valid, 0);
    end
    @(negedge clk);
    r0_valid = 1'b1; r1_valid = 1'b1;
    #1;
    chk("mid_after_r0", r0_ready, 1);
    chk("mid_after_r1", r1_ready, 0);
    @(negedge clk); r0_valid = 1'b0; r1_valid = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
